// File: rtl/sync_pkt_fifo_pkg.sv
// sync_pkt_fifo_pkg: shared widths and constants for the packet FIFO
package sync_pkt_fifo_pkg;
    localparam int STATS_W = 16;
    localparam logic [STATS_W-1:0] STATS_MAX = 16'hFFFF;

    // Pointers carry one extra bit so full and empty are distinguishable
    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction
endpackage

// File: rtl/sync_pkt_fifo_mem.sv
// sync_pkt_fifo_mem: simple dual-port RAM, synchronous write, asynchronous read
module sync_pkt_fifo_mem
    import sync_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_pkt_fifo.sv
// sync_pkt_fifo: packet FIFO with frame commit/drop and FWFT read side.
// Define SYNC_PKT_FIFO_STATS_EN to add saturating commit/drop frame counters.
module sync_pkt_fifo
    import sync_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 9,
    parameter int DEPTH_LOG2   = 11,
    parameter int AFULL_THRESH = (1 << DEPTH_LOG2) - 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wen,
    input  logic                  wcommit,
    input  logic                  wdrop,
    output logic                  full,
    output logic                  almost_full,
    output logic                  drop_pulse,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  ren,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   rd_level,
    output logic [DEPTH_LOG2:0]   free_space
`ifdef SYNC_PKT_FIFO_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [STATS_W-1:0]    frames_cmt,
    output logic [STATS_W-1:0]    frames_drop
`endif
);
    localparam int PW    = ptr_w(DEPTH_LOG2);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [PW-1:0] wr_ptr, wr_cmt, rd_ptr, used, wr_nxt;
    logic          frame_err, wr_acc, err_now, drop, commit_ok;

    assign used        = wr_ptr - rd_ptr;
    assign full        = used == PW'(DEPTH);
    assign empty       = wr_cmt == rd_ptr;
    assign almost_full = int'(used) >= AFULL_THRESH;
    assign rd_level    = wr_cmt - rd_ptr;
    assign free_space  = PW'(DEPTH) - used;

    // A word rejected for lack of space poisons the open frame, even this cycle
    assign wr_acc    = wen & ~full;
    assign wr_nxt    = wr_ptr + PW'(wr_acc);
    assign err_now   = frame_err | (wen & full);
    assign drop      = wdrop | (wcommit & err_now);
    assign commit_ok = wcommit & ~drop;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr     <= '0;
            wr_cmt     <= '0;
            rd_ptr     <= '0;
            frame_err  <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr + PW'(ren & ~empty);
            wr_ptr     <= drop ? wr_cmt : wr_nxt;
            wr_cmt     <= commit_ok ? wr_nxt : wr_cmt;
            frame_err  <= (wcommit | wdrop) ? 1'b0 : err_now;
            drop_pulse <= drop;
        end

    sync_pkt_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr[DEPTH_LOG2-1:0]),
        .wdata(din),
        .raddr(rd_ptr[DEPTH_LOG2-1:0]),
        .rdata(dout)
    );

`ifdef SYNC_PKT_FIFO_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            frames_cmt  <= '0;
            frames_drop <= '0;
        end else if (stats_clr) begin
            frames_cmt  <= '0;
            frames_drop <= '0;
        end else begin
            frames_cmt  <= (commit_ok && frames_cmt != STATS_MAX) ? frames_cmt + STATS_W'(1) : frames_cmt;
            frames_drop <= (drop_pulse && frames_drop != STATS_MAX) ? frames_drop + STATS_W'(1) : frames_drop;
        end
`endif
endmodule

// File: tb/tb_sync_pkt_fifo.sv
// tb_sync_pkt_fifo: vector table plus queue scoreboard for sync_pkt_fifo (DEPTH=16)
module tb_sync_pkt_fifo;
    localparam int DW = 9;
    localparam int L2 = 4;
    localparam int D  = 16;
    localparam int AF = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          wen = 1'b0, wcommit = 1'b0, wdrop = 1'b0, ren = 1'b0;
    logic          full, almost_full, drop_pulse, empty;
    logic [DW-1:0] dout;
    logic [L2:0]   rd_level, free_space;
`ifdef SYNC_PKT_FIFO_STATS_EN
    logic          stats_clr = 1'b0;
    logic [15:0]   frames_cmt, frames_drop;
`endif

    sync_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(L2), .AFULL_THRESH(AF)) dut (
        .clk(clk), .rst(rst), .din(din), .wen(wen), .wcommit(wcommit), .wdrop(wdrop),
        .full(full), .almost_full(almost_full), .drop_pulse(drop_pulse), .dout(dout),
        .ren(ren), .empty(empty), .rd_level(rd_level), .free_space(free_space)
`ifdef SYNC_PKT_FIFO_STATS_EN
        , .stats_clr(stats_clr), .frames_cmt(frames_cmt), .frames_drop(frames_drop)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int pend[$];
    bit merr  = 0;
    bit mdrop = 0;

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          c;
        logic          dr;
        logic          r;
        logic [DW-1:0] xdout;
        logic          xempty;
        logic [L2:0]   xlvl;
        logic [L2:0]   xfree;
        logic          xdrop;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int used_m();
        return sb.size() + pend.size();
    endfunction

    task automatic check_flags();
        chk("empty", 32'(empty), int'(sb.size() == 0));
        chk("full", 32'(full), int'(used_m() == D));
        chk("almost_full", 32'(almost_full), int'(used_m() >= AF));
        chk("rd_level", 32'(rd_level), sb.size());
        chk("free_space", 32'(free_space), D - used_m());
        chk("drop_pulse", 32'(drop_pulse), int'(mdrop));
    endtask

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic c, input logic dr, input logic r);
        bit fm;
        if (r && sb.size() > 0) chk("dout", 32'(dout), sb[0]);
        wen = w; din = d; wcommit = c; wdrop = dr; ren = r;
        @(posedge clk); #1;
        wen = 0; wcommit = 0; wdrop = 0; ren = 0;
        fm = used_m() == D;
        if (r && sb.size() > 0) void'(sb.pop_front());
        if (w) begin
            if (!fm) pend.push_back(int'(d));
            else merr = 1;
        end
        mdrop = dr || (c && merr);
        if (mdrop) begin
            pend.delete();
            merr = 0;
        end else if (c) begin
            foreach (pend[i]) sb.push_back(pend[i]);
            pend.delete();
            merr = 0;
        end
        check_flags();
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() > 0; n++) cyc(0, '0, 0, 0, 1);
        chk("drain_empty", 32'(empty), 1);
    endtask

    task automatic frame(input int n, input int base);
        for (int i = 0; i < n; i++) cyc(1, DW'(base + i), i == n - 1, 0, 0);
    endtask

    initial begin
        tv[0] = '{1, 9'h101, 0, 0, 0, 9'h000, 1, 0, 15, 0};
        tv[1] = '{1, 9'h102, 0, 0, 0, 9'h000, 1, 0, 14, 0};
        tv[2] = '{1, 9'h103, 0, 0, 0, 9'h000, 1, 0, 13, 0};
        tv[3] = '{1, 9'h104, 0, 0, 0, 9'h000, 1, 0, 12, 0};
        tv[4] = '{1, 9'h105, 1, 0, 0, 9'h000, 0, 5, 11, 0};
        tv[5] = '{0, 9'h000, 0, 0, 1, 9'h101, 0, 4, 12, 0};
        tv[6] = '{0, 9'h000, 0, 0, 1, 9'h102, 0, 3, 13, 0};
        tv[7] = '{0, 9'h000, 0, 0, 1, 9'h103, 0, 2, 14, 0};
        tv[8] = '{0, 9'h000, 0, 0, 1, 9'h104, 0, 1, 15, 0};
        tv[9] = '{0, 9'h000, 0, 0, 1, 9'h105, 1, 0, 16, 0};

        repeat (2) @(posedge clk);
        #1;
        check_flags();
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            if (tv[i].r) chk("tv_dout", 32'(dout), int'(tv[i].xdout));
            cyc(tv[i].w, tv[i].d, tv[i].c, tv[i].dr, tv[i].r);
            chk("tv_empty", 32'(empty), int'(tv[i].xempty));
            chk("tv_rd_level", 32'(rd_level), int'(tv[i].xlvl));
            chk("tv_free_space", 32'(free_space), int'(tv[i].xfree));
            chk("tv_drop_pulse", 32'(drop_pulse), int'(tv[i].xdrop));
        end

        frame(3, 'h0A0);
        for (int i = 0; i < 4; i++) cyc(1, DW'('h0B0 + i), 0, i == 3, 0);
        chk("drop_pulse_hi", 32'(drop_pulse), 1);
        chk("drop_free", 32'(free_space), D - 3);
        cyc(0, '0, 0, 0, 0);
        chk("drop_pulse_lo", 32'(drop_pulse), 0);
        drain();

        for (int i = 0; i < 20; i++) begin
            cyc(1, DW'('h150 + i), 0, 0, 0);
            if (i == 14) chk("ovf_not_full", 32'(full), 0);
            if (i == 15) chk("ovf_full", 32'(full), 1);
        end
        cyc(0, '0, 1, 0, 0);
        chk("ovf_drop", 32'(drop_pulse), 1);
        chk("ovf_empty", 32'(empty), 1);
        chk("ovf_free", 32'(free_space), D);

        for (int k = 0; k < 10; k++) begin
            frame(7, 'h40 + 16 * k);
            drain();
        end

        frame(15, 'h1C0);
        cyc(1, 9'h1F0, 0, 0, 1);
        chk("sim_free", 32'(free_space), 1);
        cyc(0, '0, 1, 1, 0);
        chk("sim_drop", 32'(drop_pulse), 1);
        chk("sim_level", 32'(rd_level), 14);
        cyc(1, 9'h1E0, 0, 0, 0);
        cyc(1, 9'h1E1, 0, 0, 0);
        chk("sim_full", 32'(full), 1);
        cyc(1, 9'h1E2, 0, 0, 1);
        chk("sim_rej_free", 32'(free_space), 1);
        cyc(0, '0, 1, 0, 0);
        chk("sim_err_drop", 32'(drop_pulse), 1);
        chk("sim_err_level", 32'(rd_level), 13);
        drain();

        repeat (400) cyc($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 7) == 0,
                         $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        cyc(0, '0, 0, 1, 0);
        drain();

        frame(2, 'h77);
        cyc(1, 9'h88, 0, 0, 0);
        cyc(1, 9'h89, 0, 0, 0);
`ifdef SYNC_PKT_FIFO_STATS_EN
        chk("stats_cmt_nz", 32'(frames_cmt != 0), 1);
`endif
        #3 rst = 1;
        #1;
        sb.delete(); pend.delete(); merr = 0; mdrop = 0;
        check_flags();
`ifdef SYNC_PKT_FIFO_STATS_EN
        chk("stats_cmt_rst", 32'(frames_cmt), 0);
        chk("stats_drop_rst", 32'(frames_drop), 0);
`endif
        @(posedge clk); #1;
        rst = 0;
        frame(4, 'h130);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/sync_pkt_fifo.md
Name: sync_pkt_fifo

Overview:
- Parametrised synchronous FIFO with packet (frame) commit/discard semantics, for the Ethernet RX/TX datapath.
- The writer streams a frame, then commits it (e.g. CRC good) or drops it (CRC bad, overflow). The reader only ever sees complete, committed frames.
- Read side is first-word-fall-through; the FIFO also reports fill level, free space and an almost-full threshold.

Parameters:
- DATA_WIDTH, 9, word width (8 data bits + 1 end-of-frame marker by convention; opaque to the FIFO).
- DEPTH_LOG2, 11, log2 of memory depth (DEPTH = 2^DEPTH_LOG2 words).
- AFULL_THRESH, 2^DEPTH_LOG2 - 64, almost_full asserts when used words (including uncommitted) >= this value.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- din  in  DATA_WIDTH  write data.
- wen  in  1  write strobe; word joins the current open frame.
- wcommit  in  1  commit the open frame (words written this cycle included).
- wdrop  in  1  discard the open frame (words written this cycle included).
- full  out  1  no free word (used == DEPTH).
- almost_full  out  1  used >= AFULL_THRESH.
- drop_pulse  out  1  one-cycle pulse whenever a frame is discarded (explicit drop or overflow).
- dout  out  DATA_WIDTH  head word; valid while empty==0.
- ren  in  1  pop head word.
- empty  out  1  no committed word available.
- rd_level  out  DEPTH_LOG2+1  committed words available to reader.
- free_space  out  DEPTH_LOG2+1  DEPTH - used.

Behaviour:
- Pointers: DEPTH_LOG2+1 bits each, natural wrap.
  - wr_ptr: speculative write pointer.
  - wr_cmt: committed write pointer.
  - rd_ptr: read pointer.
  - used = wr_ptr - rd_ptr; rd_level = wr_cmt - rd_ptr; all modulo 2^(DEPTH_LOG2+1).
- Reset:
  - All pointers 0; frame_err 0.
  - Outputs: empty=1, full=0, almost_full=0, drop_pulse=0, rd_level=0, free_space=DEPTH.
  - dout is don't-care.
- Write:
  - wen & ~full: mem[wr_ptr] <= din; wr_ptr increments.
  - wen & full: word discarded; frame_err <= 1 (sticky until frame close).
- Commit/drop, evaluated after the same-cycle write:
  - wcommit & ~wdrop & ~frame_err: wr_cmt <= new wr_ptr.
  - wdrop, or wcommit with frame_err (or frame_err set this cycle): wr_ptr <= wr_cmt, frame_err <= 0, drop_pulse=1 next cycle.
  - wdrop wins over wcommit.
  - Any close (commit or drop) clears frame_err.
- Read:
  - dout = mem[rd_ptr], combinational, zero latency.
  - ren & ~empty: rd_ptr increments.
  - ren & empty: ignored; no underflow state.
- Empty: wr_cmt == rd_ptr. Uncommitted words never make empty deassert.
- Full: used == DEPTH. A frame larger than DEPTH can never commit and is always dropped.
- Simultaneous ren and wen when full: the write is still rejected (full is sampled before the pop). A same-cycle pop frees space visible next cycle.
- Flags: full, empty, almost_full, rd_level and free_space are combinational from registered pointers. drop_pulse is registered.
- Reset mid-frame: the open frame and all committed data are lost.

Optional Feature:
- Macro SYNC_PKT_FIFO_STATS_EN.
- Defined: adds outputs frames_cmt and frames_drop (16 bits each).
  - Each saturates at 16'hFFFF.
  - Cleared by rst and by a new input stats_clr (synchronous, 1 cycle).
  - frames_cmt increments on each successful commit; frames_drop increments on each drop_pulse.
- Undefined: those ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Package sync_pkt_fifo_pkg:
  - pointer-width function (DEPTH_LOG2+1);
  - STATS_W = 16;
  - STATS_MAX constant.
- Sub-module sync_pkt_fifo_mem: simple dual-port RAM, synchronous write, asynchronous read, parametrised DATA_WIDTH and DEPTH_LOG2.
- Pointer and commit logic stay in the top.

Test Plan:
- Commit path: write 5 words 0x101..0x105, wcommit with the last wen. Empty stays 1 until the commit cycle, then rd_level=5 next cycle. Pop 5 words → dout sequence matches, then empty=1.
- Drop path: commit frame A (3 words), write frame B (4 words), assert wdrop. Then:
  - drop_pulse high 1 cycle;
  - free_space returns to DEPTH-3;
  - reader sees only A.
- Overflow: DEPTH_LOG2=4; write 20 words then wcommit.
  - full asserts at word 16;
  - frame dropped, drop_pulse=1;
  - empty remains 1; free_space=16.
- Wrap: DEPTH_LOG2=4; repeat 10× (commit 7-word frame, drain it) → data intact across pointer wrap; full never asserts.
- Simultaneous: with 15/16 used (committed), apply wen+ren in the same cycle, then wcommit+wdrop together. Then:
  - write accepted, used stays 15;
  - the close is a drop: open-frame words removed, drop_pulse=1.
- Async reset mid-frame: assert rst between clock edges during an open frame → flags return to reset values immediately. With SYNC_PKT_FIFO_STATS_EN defined, counters read 0.
